mprj_io_cfg_loader: RTL and testbench
=====================================

// Module: mprj_io_cfg_loader
// PURPOSE
// - Serial configuration loader for the user-project pad ring, split into area 1 and area 2.
// - On start, snapshots a per-pad config word for every pad, then shifts both areas' daisy chains in parallel.
// - The shift uses a divided serial clock and finishes with a load strobe, so all pad config latches update together.
// - Sits between the management config registers and the per-pad control blocks feeding the pad array.
// PARAMETERS
// - NUM_PADS   38  total user pads; pads 0..AREA1PADS-1 = area 1, AREA1PADS..NUM_PADS-1 = area 2
// - AREA1PADS  18  pad count in area 1; legal range 1..NUM_PADS-1
// - CFG_BITS   13  config bits per pad
// - CLK_DIV    4   clock cycles per serial_clock half-period; must be >= 1
// PORTS
// - clock          in   1                  system clock; all state on rising edge
// - reset          in   1                  synchronous, active-high reset
// - start          in   1                  request a full reload; sampled only in IDLE
// - cfg            in   NUM_PADS*CFG_BITS  pad p word = cfg[p*CFG_BITS +: CFG_BITS]
// - busy           out  1                  high from the cycle after an accepted start until the last LOAD cycle
// - done           out  1                  one-cycle pulse after the load strobe completes
// - serial_clock   out  1                  chain shift clock; pad chains capture on its rising edge
// - serial_load    out  1                  chain load strobe; high for CLK_DIV cycles
// - serial_data_1  out  1                  area 1 chain data
// - serial_data_2  out  1                  area 2 chain data
// BEHAVIOUR
// - Reset: state=IDLE. All outputs are 0: busy, done, serial_clock, serial_load, serial_data_1, serial_data_2.
//   - Reset asserted mid-shift aborts the load. Outputs are 0 on the next edge; no load strobe and no done.
// - N_SHIFT = max(AREA1PADS, NUM_PADS-AREA1PADS) * CFG_BITS.
// - Bit counter width is $clog2(N_SHIFT+1). Divider counter width is $clog2(CLK_DIV+1).
// - Stream 1 is {cfg word of pad AREA1PADS-1, ..., pad 0}, sent MSB first.
// - Stream 2 is {cfg word of pad NUM_PADS-1, ..., pad AREA1PADS}, sent MSB first.
// - The shorter stream is prefixed with 0 bits up to N_SHIFT bits, so both chains complete on the same edge.
// - IDLE: a start on edge t snapshots cfg into an internal register on edge t and moves to SHIFT_LO.
//   - Later changes to cfg do not affect this load.
// - SHIFT_LO (CLK_DIV cycles): serial_clock=0, serial_data_x = current stream bit, busy=1. Then go to SHIFT_HI.
// - SHIFT_HI (CLK_DIV cycles): serial_clock=1, serial_data_x held.
//   - If bits remain: advance to the next bit and return to SHIFT_LO.
//   - After bit N_SHIFT-1: go to LOAD.
//   - Data never changes while serial_clock=1.
// - LOAD (CLK_DIV cycles): serial_clock=0, serial_load=1, serial_data_x=0. Then go to DONE.
// - DONE (1 cycle): done=1, busy=0, serial_load=0. Then go to IDLE.
// - busy is high for exactly 2*CLK_DIV*N_SHIFT + CLK_DIV cycles per load.
// - start while busy or in DONE is ignored and not queued.
// - start held high in IDLE starts a new load on the cycle after DONE.
// - All outputs are registered; no combinational path from any input to any output.
// TESTING
// - Params 4/2/3/1, cfg words 3'b101,3'b011,3'b110,3'b001, start 1 cycle:
//   - busy high 13 cycles.
//   - serial_data_1 samples on serial_clock rises = 0,1,1,1,0,1.
//   - serial_data_2 samples = 0,0,1,1,1,0.
//   - serial_load high 1 cycle, then done pulses once.
// - Params 5/2/3/2, asymmetric chains: N_SHIFT=9.
//   - serial_data_1 is 0 for the first 3 rises, then pad1 and pad0 words.
//   - busy lasts 2*2*9+2 = 38 cycles.
// - start pulsed again at busy cycles 3 and 20:
//   - Ignored; exactly one done.
//   - cfg changed at cycle 5 does not alter shifted bits.
// - reset asserted during SHIFT_HI of bit 4:
//   - Next edge all outputs 0, no serial_load, no done.
//   - A fresh start afterwards completes normally.
// - Default params 38/18/13/4, random cfg:
//   - The bench model (two shift registers clocked by serial_clock, latched on serial_load) matches cfg for every pad.
//   - busy = 2*4*260+4 = 2084 cycles.
// - Every run: serial_data_x is stable while serial_clock=1, and serial_clock=0 whenever serial_load=1.

Source files
------------

// File: rtl/mprj_io_cfg_loader.sv
// Serial configuration loader for the user-project pad ring: snapshots one config word per pad,
// then shifts area 1 and area 2 daisy chains in parallel and finishes with a common load strobe.
module mprj_io_cfg_loader #(
    parameter int unsigned NUM_PADS  = 38,
    parameter int unsigned AREA1PADS = 18,
    parameter int unsigned CFG_BITS  = 13,
    parameter int unsigned CLK_DIV   = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic [NUM_PADS*CFG_BITS-1:0] cfg,
    output logic                         busy,
    output logic                         done,
    output logic                         serial_clock,
    output logic                         serial_load,
    output logic                         serial_data_1,
    output logic                         serial_data_2
);

    localparam int unsigned AREA2PADS = NUM_PADS - AREA1PADS;
    localparam int unsigned A1_BITS   = AREA1PADS * CFG_BITS;
    localparam int unsigned A2_BITS   = AREA2PADS * CFG_BITS;
    localparam int unsigned N_SHIFT   = (A1_BITS > A2_BITS) ? A1_BITS : A2_BITS;
    localparam int unsigned BIT_W     = $clog2(N_SHIFT + 1);
    localparam int unsigned DIV_W     = $clog2(CLK_DIV + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SHIFT_LO = 3'd1;
    localparam logic [2:0] S_SHIFT_HI = 3'd2;
    localparam logic [2:0] S_LOAD     = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [DIV_W-1:0]   r_div;
    logic [BIT_W-1:0]   r_bit_cnt;
    logic [N_SHIFT-1:0] r_sr1;
    logic [N_SHIFT-1:0] r_sr2;
    logic [N_SHIFT-1:0] w_stream1;
    logic [N_SHIFT-1:0] w_stream2;
    logic               r_busy;
    logic               r_done;
    logic               r_sclk;
    logic               r_load;
    logic               w_div_last;
    logic               w_last_bit;
    logic               w_accept;
    logic               w_bit_end;

    assign w_div_last = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_last_bit = (r_bit_cnt == BIT_W'(N_SHIFT - 1));
    assign w_accept   = (r_state == S_IDLE) && start;
    assign w_bit_end  = (r_state == S_SHIFT_HI) && w_div_last;

    // Zero-extend the shorter area so both chains finish on the same serial_clock edge.
    always_comb begin
        w_stream1                = '0;
        w_stream2                = '0;
        w_stream1[A1_BITS-1:0]   = cfg[A1_BITS-1:0];
        w_stream2[A2_BITS-1:0]   = cfg[NUM_PADS*CFG_BITS-1:A1_BITS];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_next_state = S_SHIFT_LO;
            end
            S_SHIFT_LO: begin
                if (w_div_last) w_next_state = S_SHIFT_HI;
            end
            S_SHIFT_HI: begin
                if (w_div_last) w_next_state = w_last_bit ? S_LOAD : S_SHIFT_LO;
            end
            S_LOAD: begin
                if (w_div_last) w_next_state = S_DONE;
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Phase divider restarts on every state change; bit stream shifts as serial_clock falls.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_div     <= '0;
            r_bit_cnt <= '0;
            r_sr1     <= '0;
            r_sr2     <= '0;
        end else begin
            if ((r_state == S_IDLE) || (w_next_state != r_state)) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + DIV_W'(1);
            end

            if (w_accept) begin
                r_bit_cnt <= '0;
                r_sr1     <= w_stream1;
                r_sr2     <= w_stream2;
            end else if (w_bit_end) begin
                r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                r_sr1     <= r_sr1 << 1;
                r_sr2     <= r_sr2 << 1;
            end
        end
    end

    // Outputs are decoded from the next state so they line up with the registered state.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_sclk <= 1'b0;
            r_load <= 1'b0;
        end else begin
            r_busy <= (w_next_state == S_SHIFT_LO) || (w_next_state == S_SHIFT_HI) ||
                      (w_next_state == S_LOAD);
            r_done <= (w_next_state == S_DONE);
            r_sclk <= (w_next_state == S_SHIFT_HI);
            r_load <= (w_next_state == S_LOAD);
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign serial_clock  = r_sclk;
    assign serial_load   = r_load;
    assign serial_data_1 = r_sr1[N_SHIFT-1];
    assign serial_data_2 = r_sr2[N_SHIFT-1];

endmodule

// File: tb/tb_mprj_io_cfg_loader.sv
// Scoreboard bench for mprj_io_cfg_loader: three parameter sets, pad chains modelled as shift
// registers clocked by serial_clock and compared against the snapshot cfg when serial_load drops.
`timescale 1ns/1ps
module tb_mprj_io_cfg_loader;

    localparam int unsigned MAXW = 494;
    localparam int unsigned MAXC = 260;
    localparam int NP_L   [3] = '{4, 5, 38};
    localparam int A1_L   [3] = '{2, 2, 18};
    localparam int CB_L   [3] = '{3, 3, 13};
    localparam int CD_L   [3] = '{1, 2, 4};
    localparam int NS_L   [3] = '{6, 9, 260};
    localparam int BUSY_L [3] = '{13, 38, 2084};

    logic            clk = 1'b0;
    logic            rst_v   [3];
    logic            start_v [3];
    logic [MAXW-1:0] cfg_v   [3];
    logic            busy_v  [3];
    logic            done_v  [3];
    logic            sclk_v  [3];
    logic            load_v  [3];
    logic            d1_v    [3];
    logic            d2_v    [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mprj_io_cfg_loader #(
            .NUM_PADS (NP_L[g]),
            .AREA1PADS(A1_L[g]),
            .CFG_BITS (CB_L[g]),
            .CLK_DIV  (CD_L[g])
        ) u_dut (
            .clock        (clk),
            .reset        (rst_v[g]),
            .start        (start_v[g]),
            .cfg          (cfg_v[g][NP_L[g]*CB_L[g]-1:0]),
            .busy         (busy_v[g]),
            .done         (done_v[g]),
            .serial_clock (sclk_v[g]),
            .serial_load  (load_v[g]),
            .serial_data_1(d1_v[g]),
            .serial_data_2(d2_v[g])
        );
    end

    initial forever #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    bit          q_d1   [$];
    bit          q_d2   [$];
    logic [12:0] q_word [$];
    int          done_tok = 0;

    logic            rst_e  [3];
    logic            sclk_p [3];
    logic            busy_p [3];
    logic            load_p [3];
    logic            h1     [3];
    logic            h2     [3];
    int              busy_n [3];
    int              load_n [3];
    logic [MAXC-1:0] ch1    [3];
    logic [MAXC-1:0] ch2    [3];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic monitor_inst(input int g);
        logic [12:0] w;
        string       t;
        t = $sformatf("u%0d", g);
        if (rst_e[g]) begin
            check_eq({t, ".reset_outputs"},
                     64'({busy_v[g], done_v[g], sclk_v[g], load_v[g], d1_v[g], d2_v[g]}), 64'd0);
            busy_n[g] = 0;
            load_n[g] = 0;
        end else begin
            if (sclk_v[g] && !sclk_p[g]) begin
                if (q_d1.size() == 0 || q_d2.size() == 0) begin
                    check_eq({t, ".bits_expected"}, 64'(q_d1.size()), 64'd1);
                end else begin
                    check_eq({t, ".data1"}, 64'(d1_v[g]), 64'(q_d1.pop_front()));
                    check_eq({t, ".data2"}, 64'(d2_v[g]), 64'(q_d2.pop_front()));
                end
                ch1[g] = {ch1[g][MAXC-2:0], d1_v[g]};
                ch2[g] = {ch2[g][MAXC-2:0], d2_v[g]};
                h1[g]  = d1_v[g];
                h2[g]  = d2_v[g];
            end else if (sclk_v[g]) begin
                check_eq({t, ".data_stable_hi"}, 64'({d1_v[g], d2_v[g]}), 64'({h1[g], h2[g]}));
            end
            if (load_v[g]) check_eq({t, ".load_quiet"}, 64'({sclk_v[g], d1_v[g], d2_v[g]}), 64'd0);
            if (busy_v[g]) begin
                busy_n[g]++;
            end else if (busy_p[g]) begin
                check_eq({t, ".busy_len"}, 64'(busy_n[g]), 64'(BUSY_L[g]));
                busy_n[g] = 0;
            end
            if (load_v[g]) begin
                load_n[g]++;
            end else if (load_p[g]) begin
                check_eq({t, ".load_len"}, 64'(load_n[g]), 64'(CD_L[g]));
                load_n[g] = 0;
                for (int p = 0; p < NP_L[g]; p++) begin
                    w = '0;
                    for (int b = 0; b < CB_L[g]; b++) begin
                        w[b] = (p < A1_L[g]) ? ch1[g][p*CB_L[g]+b] : ch2[g][(p-A1_L[g])*CB_L[g]+b];
                    end
                    if (q_word.size() == 0) begin
                        check_eq({t, ".word_expected"}, 64'(q_word.size()), 64'd1);
                    end else begin
                        check_eq($sformatf("%s.pad%0d", t, p), 64'(w), 64'(q_word.pop_front()));
                    end
                end
            end
            if (done_v[g]) begin
                check_eq({t, ".done_after_load"}, 64'(load_p[g]), 64'd1);
                check_eq({t, ".done_expected"}, 64'(done_tok > 0), 64'd1);
                if (done_tok > 0) done_tok--;
            end
        end
        sclk_p[g] = sclk_v[g];
        busy_p[g] = busy_v[g];
        load_p[g] = load_v[g];
    endtask

    task automatic monitor();
        forever begin
            @(posedge clk);
            for (int g = 0; g < 3; g++) rst_e[g] = rst_v[g];
            @(negedge clk);
            for (int g = 0; g < 3; g++) monitor_inst(g);
        end
    endtask

    task automatic push_words(input int g, input logic [MAXW-1:0] c);
        logic [12:0] w;
        for (int p = 0; p < NP_L[g]; p++) begin
            w = '0;
            for (int b = 0; b < CB_L[g]; b++) w[b] = c[p*CB_L[g]+b];
            q_word.push_back(w);
        end
        done_tok++;
    endtask

    // Stream model: area words concatenated high pad first, zero-padded at the front, MSB first.
    task automatic push_model(input int g, input logic [MAXW-1:0] c);
        int a1b;
        int a2b;
        a1b = A1_L[g] * CB_L[g];
        a2b = (NP_L[g] - A1_L[g]) * CB_L[g];
        for (int i = NS_L[g] - 1; i >= 0; i--) begin
            q_d1.push_back((i < a1b) ? c[i] : 1'b0);
            q_d2.push_back((i < a2b) ? c[a1b+i] : 1'b0);
        end
        push_words(g, c);
    endtask

    function automatic logic [MAXW-1:0] rand_cfg(input int g);
        logic [MAXW-1:0] c;
        c = '0;
        for (int i = 0; i < NP_L[g] * CB_L[g]; i++) c[i] = 1'($urandom_range(1, 0));
        return c;
    endfunction

    task automatic pulse_start(input int g);
        @(posedge clk); #1 start_v[g] = 1'b1;
        @(posedge clk); #1 start_v[g] = 1'b0;
    endtask

    task automatic wait_done(input int g, input int budget);
        int n;
        n = 0;
        while (!done_v[g] && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check_eq($sformatf("u%0d.done_seen", g), 64'(done_v[g]), 64'd1);
    endtask

    task automatic run_tests();
        bit              lit1 [6];
        bit              lit2 [6];
        logic [MAXW-1:0] c;
        int              n;
        int              n_r;
        int              seen;
        logic            prev;
        lit1 = '{0, 1, 1, 1, 0, 1};
        lit2 = '{0, 0, 1, 1, 1, 0};

        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) rst_v[g] = 1'b0;
        repeat (2) @(posedge clk);

        // Small chain with known words and literal expected bit sequences.
        c = '0;
        c[11:0] = 12'b001_110_011_101;
        cfg_v[0] = c;
        for (int i = 0; i < 6; i++) begin
            q_d1.push_back(lit1[i]);
            q_d2.push_back(lit2[i]);
        end
        push_words(0, c);
        pulse_start(0);
        wait_done(0, 100);
        repeat (3) @(negedge clk);

        // start held high: a second load must begin right after DONE.
        c = rand_cfg(0);
        cfg_v[0] = c;
        push_model(0, c);
        push_model(0, c);
        @(posedge clk); #1 start_v[0] = 1'b1;
        wait_done(0, 100);
        n = 0;
        while (!busy_v[0] && n < 10) begin
            @(negedge clk); #1;
            n++;
        end
        check_eq("u0.restart_busy", 64'(busy_v[0]), 64'd1);
        start_v[0] = 1'b0;
        wait_done(0, 100);
        repeat (3) @(negedge clk);

        // Asymmetric chains; stray starts and a cfg change mid-load must have no effect.
        c = rand_cfg(1);
        cfg_v[1] = c;
        push_model(1, c);
        pulse_start(1);
        for (int i = 2; i <= 21; i++) begin
            @(posedge clk); #1;
            start_v[1] = (i == 3 || i == 20);
            if (i == 5) cfg_v[1] = ~c;
        end
        start_v[1] = 1'b0;
        wait_done(1, 100);
        repeat (5) @(negedge clk);

        // Reset during SHIFT_HI of bit 4 aborts without load or done.
        c = rand_cfg(1);
        cfg_v[1] = c;
        push_model(1, c);
        pulse_start(1);
        n = 0;
        n_r = 0;
        prev = 1'b0;
        while (n_r < 5 && n < 200) begin
            @(negedge clk); #1;
            if (sclk_v[1] && !prev) n_r++;
            prev = sclk_v[1];
            n++;
        end
        check_eq("u1.abort_point", 64'(n_r), 64'd5);
        rst_v[1] = 1'b1;
        @(posedge clk); #1 rst_v[1] = 1'b0;
        q_d1.delete();
        q_d2.delete();
        q_word.delete();
        done_tok = 0;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); #1;
            if (load_v[1] || done_v[1] || busy_v[1]) seen++;
        end
        check_eq("u1.abort_quiet", 64'(seen), 64'd0);

        c = rand_cfg(1);
        cfg_v[1] = c;
        push_model(1, c);
        pulse_start(1);
        wait_done(1, 100);
        repeat (3) @(negedge clk);

        // Full-size pad ring with random configuration words.
        for (int k = 0; k < 2; k++) begin
            c = rand_cfg(2);
            cfg_v[2] = c;
            push_model(2, c);
            pulse_start(2);
            wait_done(2, 2500);
            repeat (3) @(negedge clk);
        end

        check_eq("leftover_bits", 64'(q_d1.size() + q_d2.size()), 64'd0);
        check_eq("leftover_words", 64'(q_word.size()), 64'd0);
        check_eq("leftover_done", 64'(done_tok), 64'd0);
    endtask

    initial begin
        for (int g = 0; g < 3; g++) begin
            rst_v[g]   = 1'b1;
            start_v[g] = 1'b0;
            cfg_v[g]   = '0;
            rst_e[g]   = 1'b1;
            sclk_p[g]  = 1'b0;
            busy_p[g]  = 1'b0;
            load_p[g]  = 1'b0;
            h1[g]      = 1'b0;
            h2[g]      = 1'b0;
            busy_n[g]  = 0;
            load_n[g]  = 0;
            ch1[g]     = '0;
            ch2[g]     = '0;
        end
        fork
            monitor();
            run_tests();
        join_any
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
